tl_bus_arbiter: RTL and testbench

TL_BUS_ARBITER -- requirements
Module: tl_bus_arbiter

---
 rtl/tl_bus_arbiter.sv | 132 +++++++++++++
 tb/tb_tl_bus_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_bus_arbiter.sv
// Two-master (ICache/DCache) arbiter onto a single TileLink-style bus with an
// outstanding-request limit; grant is held until the owner goes quiet and all of its responses return.
module tl_bus_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        io_icache_req_valid,
  output logic        io_icache_req_ready,
  input  logic [2:0]  io_icache_req_bits_opcode,
  input  logic [31:0] io_icache_req_bits_address,
  input  logic [31:0] io_icache_req_bits_data,
  output logic        io_icache_resp_valid,
  output logic [2:0]  io_icache_resp_bits_opcode,
  output logic [31:0] io_icache_resp_bits_data,

  input  logic        io_dcache_req_valid,
  output logic        io_dcache_req_ready,
  input  logic [2:0]  io_dcache_req_bits_opcode,
  input  logic [31:0] io_dcache_req_bits_address,
  input  logic [31:0] io_dcache_req_bits_data,
  output logic        io_dcache_resp_valid,
  output logic [2:0]  io_dcache_resp_bits_opcode,
  output logic [31:0] io_dcache_resp_bits_data,

  output logic        io_tlbus_req_valid,
  input  logic        io_tlbus_req_ready,
  output logic [2:0]  io_tlbus_req_bits_opcode,
  output logic [31:0] io_tlbus_req_bits_address,
  output logic [31:0] io_tlbus_req_bits_data,
  input  logic        io_tlbus_resp_valid,
  input  logic [2:0]  io_tlbus_resp_bits_opcode,
  input  logic [31:0] io_tlbus_resp_bits_data,

  output logic        io_err
);

  localparam logic [2:0] MaxCnt = 3'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {StIdle, StOwnI, StOwnD} stateT;

  stateT      stateQ, stateD;
  logic [2:0] cntQ, cntD;
  logic       lastDcacheQ, lastDcacheD;
  logic       errQ, errD;

  logic ownI, ownD, canIssue, ownerValid, fire, respAccept;

  always_comb begin
    ownI       = (stateQ == StOwnI);
    ownD       = (stateQ == StOwnD);
    // Gate on the registered count so a same-cycle response never frees a slot early.
    canIssue   = (cntQ < MaxCnt);
    ownerValid = (ownI && io_icache_req_valid) || (ownD && io_dcache_req_valid);

    io_tlbus_req_valid        = ownerValid && canIssue;
    io_tlbus_req_bits_opcode  = ownD ? io_dcache_req_bits_opcode  : io_icache_req_bits_opcode;
    io_tlbus_req_bits_address = ownD ? io_dcache_req_bits_address : io_icache_req_bits_address;
    io_tlbus_req_bits_data    = ownD ? io_dcache_req_bits_data    : io_icache_req_bits_data;

    io_icache_req_ready = ownI && io_tlbus_req_ready && canIssue;
    io_dcache_req_ready = ownD && io_tlbus_req_ready && canIssue;

    fire       = io_tlbus_req_valid && io_tlbus_req_ready;
    // A response is only expected while someone owns the bus and has requests in flight.
    respAccept = io_tlbus_resp_valid && (ownI || ownD) && (cntQ != 3'd0);

    io_icache_resp_valid       = ownI && respAccept;
    io_dcache_resp_valid       = ownD && respAccept;
    io_icache_resp_bits_opcode = io_tlbus_resp_bits_opcode;
    io_icache_resp_bits_data   = io_tlbus_resp_bits_data;
    io_dcache_resp_bits_opcode = io_tlbus_resp_bits_opcode;
    io_dcache_resp_bits_data   = io_tlbus_resp_bits_data;

    io_err = errQ;
  end

  always_comb begin
    cntD = cntQ;
    unique case ({fire, respAccept})
      2'b10:   cntD = cntQ + 3'd1;
      2'b01:   cntD = cntQ - 3'd1;
      default: cntD = cntQ;
    endcase
    errD = errQ | (io_tlbus_resp_valid & ~respAccept);
  end

  always_comb begin
    stateD      = stateQ;
    lastDcacheD = lastDcacheQ;
    unique case (stateQ)
      StIdle: begin
        if (io_icache_req_valid && io_dcache_req_valid) begin
          stateD = lastDcacheQ ? StOwnI : StOwnD;
        end else if (io_icache_req_valid) begin
          stateD = StOwnI;
        end else if (io_dcache_req_valid) begin
          stateD = StOwnD;
        end
      end
      StOwnI: begin
        if (!io_icache_req_valid && (cntD == 3'd0)) begin
          stateD      = StIdle;
          lastDcacheD = 1'b0;
        end
      end
      StOwnD: begin
        if (!io_dcache_req_valid && (cntD == 3'd0)) begin
          stateD      = StIdle;
          lastDcacheD = 1'b1;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stateQ      <= StIdle;
      cntQ        <= 3'd0;
      lastDcacheQ <= 1'b1;
      errQ        <= 1'b0;
    end else begin
      stateQ      <= stateD;
      cntQ        <= cntD;
      lastDcacheQ <= lastDcacheD;
      errQ        <= errD;
    end
  end

endmodule

// File: tb/tb_tl_bus_arbiter.sv
// Randomized and directed bench for tl_bus_arbiter, checked against a queue-based
// model of ownership, in-flight requests and the sticky error flag.
module tb_tl_bus_arbiter;

  localparam int unsigned MaxOut = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        iValid = 1'b0, dValid = 1'b0, busReady = 1'b0, respValid = 1'b0;
  logic [2:0]  iOp = '0, dOp = '0, respOp = '0;
  logic [31:0] iAddr = '0, iData = '0, dAddr = '0, dData = '0, respData = '0;

  logic        iReady, iRespValid, dReady, dRespValid, busValid, err;
  logic [2:0]  iRespOp, dRespOp, busOp;
  logic [31:0] iRespData, dRespData, busAddr, busData;

  tl_bus_arbiter #(.MAX_OUTSTANDING(MaxOut)) dut (
    .clock(clock), .reset(reset),
    .io_icache_req_valid(iValid), .io_icache_req_ready(iReady),
    .io_icache_req_bits_opcode(iOp), .io_icache_req_bits_address(iAddr),
    .io_icache_req_bits_data(iData),
    .io_icache_resp_valid(iRespValid), .io_icache_resp_bits_opcode(iRespOp),
    .io_icache_resp_bits_data(iRespData),
    .io_dcache_req_valid(dValid), .io_dcache_req_ready(dReady),
    .io_dcache_req_bits_opcode(dOp), .io_dcache_req_bits_address(dAddr),
    .io_dcache_req_bits_data(dData),
    .io_dcache_resp_valid(dRespValid), .io_dcache_resp_bits_opcode(dRespOp),
    .io_dcache_resp_bits_data(dRespData),
    .io_tlbus_req_valid(busValid), .io_tlbus_req_ready(busReady),
    .io_tlbus_req_bits_opcode(busOp), .io_tlbus_req_bits_address(busAddr),
    .io_tlbus_req_bits_data(busData),
    .io_tlbus_resp_valid(respValid), .io_tlbus_resp_bits_opcode(respOp),
    .io_tlbus_resp_bits_data(respData),
    .io_err(err)
  );

  always #5 clock = ~clock;

  // Reference model: who owns the bus (0 none, 1 ICache, 2 DCache), the addresses
  // of requests still waiting for a response, and the round-robin memory.
  int          owner = 0;
  logic [31:0] pend[$];
  bit          dWonLast = 1'b1;
  bit          modelErr = 1'b0;

  int nChecks = 0;
  int nPass   = 0;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic modelReset();
    owner = 0;
    pend.delete();
    dWonLast = 1'b1;
    modelErr = 1'b0;
  endtask

  // Called at a falling edge with inputs already applied: check, advance model, clock.
  task automatic step();
    bit full, expValid, respOk, fire, ownerHolds;
    #1;
    full     = pend.size() >= MaxOut;
    expValid = (owner == 1) ? (iValid && !full) : (owner == 2) ? (dValid && !full) : 1'b0;
    respOk   = respValid && (owner != 0) && (pend.size() > 0);
    checkEq("busValid", busValid, expValid);
    checkEq("iReady", iReady, (owner == 1) && busReady && !full);
    checkEq("dReady", dReady, (owner == 2) && busReady && !full);
    checkEq("iRespValid", iRespValid, (owner == 1) && respOk);
    checkEq("dRespValid", dRespValid, (owner == 2) && respOk);
    checkEq("err", err, modelErr);
    if (expValid) begin
      checkEq("busAddr", busAddr, (owner == 1) ? iAddr : dAddr);
      checkEq("busData", busData, (owner == 1) ? iData : dData);
      checkEq("busOp", busOp, (owner == 1) ? iOp : dOp);
    end
    if (respOk) begin
      checkEq("iRespData", iRespData, respData);
      checkEq("dRespData", dRespData, respData);
      checkEq("dRespOp", dRespOp, respOp);
    end

    fire = expValid && busReady;
    if (respOk) void'(pend.pop_front());
    if (fire) pend.push_back(busAddr);
    if (respValid && !respOk) modelErr = 1'b1;
    if (owner == 0) begin
      if (iValid && dValid) owner = dWonLast ? 1 : 2;
      else if (iValid)      owner = 1;
      else if (dValid)      owner = 2;
    end else begin
      ownerHolds = (owner == 1) ? iValid : dValid;
      if (!ownerHolds && pend.size() == 0) begin
        dWonLast = (owner == 2);
        owner    = 0;
      end
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic quiet();
    iValid = 0; dValid = 0; busReady = 0; respValid = 0;
  endtask

  // Return every in-flight response, then let the arbiter fall back to idle.
  task automatic drain();
    quiet();
    for (int k = 0; k < 16 && pend.size() > 0; k++) begin
      respValid = 1; respData = $urandom; respOp = 3'($urandom);
      step();
    end
    respValid = 0;
    step();
    step();
    checkEq("drained", pend.size(), 0);
  endtask

  task automatic doReset();
    reset = 0;
    #1;
    checkEq("rstBusValid", busValid, 0);
    checkEq("rstIReady", iReady, 0);
    checkEq("rstDReady", dReady, 0);
    checkEq("rstErr", err, 0);
    modelReset();
    @(negedge clock);
    quiet();
    reset = 1;
    @(negedge clock);
  endtask

  initial begin
    modelReset();
    @(negedge clock);
    @(negedge clock);
    reset = 1;

    // Both request right after reset: ICache first, DCache at the next arbitration.
    iValid = 1; dValid = 1; iAddr = 32'h0000_1000; dAddr = 32'h0000_2000;
    iOp = 3'd4; dOp = 3'd4; busReady = 0;
    step();
    #1;
    checkEq("bothFirstBusAddr", busAddr, 32'h0000_1000);
    checkEq("bothFirstValid", busValid, 1);
    step();
    iValid = 0;
    step();
    step();
    busReady = 1;
    #1;
    checkEq("dGrantedNext", dReady, 1);
    checkEq("dGrantAddr", busAddr, 32'h0000_2000);
    step();
    drain();

    // ICache fills the outstanding window; one response reopens it a cycle later.
    iValid = 1; iOp = 3'd4; busReady = 1;
    step();
    for (int k = 0; k < 4; k++) begin iAddr = 32'h100 + 4 * k; step(); end
    #1;
    checkEq("fullIReady", iReady, 0);
    respValid = 1; respData = 32'h1234_5678;
    #1;
    checkEq("fullSameCycleReady", iReady, 0);
    step();
    respValid = 0;
    #1;
    checkEq("reopenIReady", iReady, 1);
    drain();

    // DCache keeps the bus with two in flight while ICache waits.
    dValid = 1; busReady = 1; dOp = 3'd0;
    step(); step(); step();
    dValid = 0; iValid = 1; busReady = 1;
    #1;
    checkEq("waitIReady0", iReady, 0);
    respValid = 1; step();
    #1;
    checkEq("waitIReady1", iReady, 0);
    step();
    respValid = 0;
    #1;
    checkEq("idleBusValid", busValid, 0);
    step();
    #1;
    checkEq("iGrantAfter", iReady, 1);
    drain();

    // Single DCache request answered with 0xDEADBEEF.
    dValid = 1; busReady = 1;
    step(); step();
    dValid = 0; busReady = 0; respValid = 1; respData = 32'hDEAD_BEEF;
    #1;
    checkEq("beefDResp", dRespValid, 1);
    checkEq("beefIResp", iRespValid, 0);
    checkEq("beefData", dRespData, 32'hDEAD_BEEF);
    step();
    respValid = 0;
    step();
    checkEq("beefNoErr", err, 0);

    // Stray response while idle is dropped and flagged.
    respValid = 1;
    #1;
    checkEq("strayIResp", iRespValid, 0);
    checkEq("strayDResp", dRespValid, 0);
    step();
    respValid = 0;
    step();
    checkEq("strayErr", err, 1);

    // Reset with three ICache requests in flight; a late response is unexpected.
    doReset();
    iValid = 1; busReady = 1;
    step(); step(); step(); step();
    doReset();
    respValid = 1;
    step();
    respValid = 0;
    step();
    checkEq("lateRespErr", err, 1);
    iValid = 1; dValid = 1; busReady = 1;
    #1;
    step();
    #1;
    checkEq("postRstIFirst", iReady, 1);
    drain();
    doReset();

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(3) == 0) iValid = ~iValid;
      if ($urandom_range(3) == 0) dValid = ~dValid;
      busReady  = ($urandom_range(3) != 0);
      respValid = (pend.size() > 0) ? ($urandom_range(2) == 0) : ($urandom_range(60) == 0);
      iAddr = $urandom; iData = $urandom; iOp = 3'($urandom);
      dAddr = $urandom; dData = $urandom; dOp = 3'($urandom);
      respData = $urandom; respOp = 3'($urandom);
      if (c == 750) doReset();
      else step();
    end
    drain();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
